// File: rtl/tp_issuer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tp_issuer
// Purpose  : Initiator for the two-operand taint/timing test unit. Operand
//            pairs are queued in a small FIFO, driven onto the unit inputs,
//            held for a fixed number of cycles, then the unit output is
//            returned on a valid/ready response port. The wait is
//            data-independent, so the unit's zero fast path never shows up
//            as a difference in response time.
// Ports    : clk, rst_n          - clock (rising edge), async active-low reset
//            req_valid/req_ready - upstream operand pair handshake
//            req_a, req_b        - operands
//            dut_in1, dut_in2    - registered drive to the unit inputs
//            dut_out             - unit result
//            rsp_valid/rsp_ready - downstream result handshake
//            rsp_data            - captured result
//            level               - FIFO occupancy
//            busy                - transaction in flight or response pending
// Revision : 1.0 - initial release
// ============================================================================
module tp_issuer #(
    parameter int W     = 2,
    parameter int DEPTH = 4,
    parameter int LAT   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [W-1:0]             req_a,
    input  logic [W-1:0]             req_b,
    output logic [W-1:0]             dut_in1,
    output logic [W-1:0]             dut_in2,
    input  logic [W-1:0]             dut_out,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [W-1:0]             rsp_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = (LAT < 1) ? 1 : $clog2(LAT + 1);
    localparam logic [c_aw:0]   c_full = (c_aw + 1)'(DEPTH);
    localparam logic [c_cw-1:0] c_lat  = c_cw'(LAT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [2*W-1:0]  r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_level;
    logic [c_cw-1:0] r_cnt;
    logic [W-1:0]    r_in1;
    logic [W-1:0]    r_in2;
    logic [W-1:0]    r_rsp_data;
    logic            r_rsp_valid;

    logic            w_push;
    logic            w_load;
    logic            w_capture;
    logic            w_rsp_clr;
    logic            w_not_empty;
    logic [2*W-1:0]  w_head;

    assign w_not_empty = (r_level != '0);
    assign req_ready   = (r_level != c_full);
    assign w_push      = req_valid && req_ready;
    assign w_head      = r_mem[r_rd_ptr];

    assign dut_in1   = r_in1;
    assign dut_in2   = r_in2;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign level     = r_level;
    assign busy      = (r_state != S_IDLE);

    // Storage needs no reset: occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {req_a, req_b};
        end
    end

    // Next-state logic. A load (FIFO pop) happens either from IDLE or on the
    // accept edge of a response, which gives back-to-back transactions.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_capture   = 1'b0;
        w_rsp_clr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_not_empty) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // Fixed count regardless of operands keeps timing constant.
                if (r_cnt == c_lat) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_rsp_clr = 1'b1;
                    if (w_not_empty) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_cnt       <= '0;
            r_in1       <= '0;
            r_in2       <= '0;
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({w_push, w_load})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase

            // Unit inputs keep the last pair between transactions.
            if (w_load) begin
                r_in1 <= w_head[2*W-1:W];
                r_in2 <= w_head[W-1:0];
                r_cnt <= '0;
            end else if (r_state == S_WAIT && !w_capture) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_capture) begin
                r_rsp_data  <= dut_out;
                r_rsp_valid <= 1'b1;
            end else if (w_rsp_clr) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
